inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 138 +++++++++++++
 tb/tb_inst_fetch.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch unit: memory read sequencer feeding a 2-entry
// {pc, inst} FIFO, with redirect flush and abandoned-request drain.
module inst_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h4300
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] inst_out,
  output logic [15:0] inst_pc,
  output logic        inst_valid,
  output logic        ir_wen
);

  typedef enum logic {
    S_FETCH,
    S_DRAIN
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_fetch_pc;
  logic [15:0] r_drain_addr;
  logic [1:0]  r_cnt;
  logic [15:0] r_pc0;
  logic [15:0] r_pc1;
  logic [15:0] r_in0;
  logic [15:0] r_in1;
  logic        w_req;
  logic [15:0] w_addr;
  logic        w_done;
  logic        w_push;
  logic        w_pop;
  logic        w_valid;
  logic [15:0] w_rpc;

  assign w_rpc   = redirect_pc & 16'hFFFE;
  assign w_done  = w_req & mem_ack;
  assign w_push  = (r_state == S_FETCH) & w_done & ~redirect;
  assign w_valid = (r_cnt != 2'd0);
  assign w_pop   = w_valid & ~stall & ~redirect;

  assign mem_req    = w_req;
  assign mem_addr   = w_addr;
  assign inst_valid = w_valid;
  assign ir_wen     = w_pop;
  assign inst_out   = w_valid ? r_in0 : NOP_INST;
  assign inst_pc    = w_valid ? r_pc0 : 16'h0000;

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_FETCH;
    else         r_state <= w_next;
  end

  // FSM next state: drain a request abandoned by a redirect
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FETCH: if (redirect & w_req & ~mem_ack) w_next = S_DRAIN;
      S_DRAIN: if (w_done) w_next = S_FETCH;
      default: w_next = S_FETCH;
    endcase
  end

  // FSM outputs: request gated by reset so it drops asynchronously
  always_comb begin
    w_req  = 1'b0;
    w_addr = r_fetch_pc;
    unique case (r_state)
      S_FETCH: w_req = resetn & (r_cnt != 2'd2);
      S_DRAIN: begin
        w_req  = resetn;
        w_addr = r_drain_addr;
      end
      default: w_req = 1'b0;
    endcase
  end

  // Fetch pointer: redirect target wins, else advance on push
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       r_fetch_pc <= RESET_PC;
    else if (redirect) r_fetch_pc <= w_rpc;
    else if (w_push)   r_fetch_pc <= r_fetch_pc + 16'd2;
  end

  // Hold the abandoned address stable until its ack arrives
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_drain_addr <= 16'h0000;
    else if (r_state == S_FETCH && w_next == S_DRAIN)
      r_drain_addr <= r_fetch_pc;
  end

  // Two-entry FIFO, entry 0 is the head
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= 2'd0;
      r_pc0 <= 16'h0000;
      r_pc1 <= 16'h0000;
      r_in0 <= 16'h0000;
      r_in1 <= 16'h0000;
    end else if (redirect) begin
      r_cnt <= 2'd0;
    end else if (w_push && !w_pop) begin
      r_cnt <= r_cnt + 2'd1;
      if (r_cnt == 2'd0) begin
        r_pc0 <= r_fetch_pc;
        r_in0 <= mem_rdata;
      end else begin
        r_pc1 <= r_fetch_pc;
        r_in1 <= mem_rdata;
      end
    end else if (!w_push && w_pop) begin
      r_cnt <= r_cnt - 2'd1;
      r_pc0 <= r_pc1;
      r_in0 <= r_in1;
    end else if (w_push && w_pop) begin
      if (r_cnt == 2'd1) begin
        r_pc0 <= r_fetch_pc;
        r_in0 <= mem_rdata;
      end else begin
        r_pc0 <= r_pc1;
        r_in0 <= r_in1;
        r_pc1 <= r_fetch_pc;
        r_in1 <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: vector table plus
// hand sequences for drain and asynchronous reset.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        resetn;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] inst_out;
  logic [15:0] inst_pc;
  logic        inst_valid;
  logic        ir_wen;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic        st;
    logic        rd;
    logic [15:0] rpc;
    logic        ack;
    logic [15:0] rdat;
    logic        req;
    logic [15:0] addr;
    logic        vld;
    logic        wen;
    logic [15:0] inst;
    logic [15:0] ipc;
  } vec_t;

  vec_t tbl[21];

  inst_fetch dut (
    .clk         (clk),
    .resetn      (resetn),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .ir_wen      (ir_wen)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk(input string nm, input logic req,
                     input logic [15:0] addr, input logic vld,
                     input logic wen, input logic [15:0] inst,
                     input logic [15:0] ipc);
    cmp({nm, ".req"}, {15'd0, mem_req}, {15'd0, req});
    if (req) cmp({nm, ".addr"}, mem_addr, addr);
    cmp({nm, ".vld"}, {15'd0, inst_valid}, {15'd0, vld});
    cmp({nm, ".wen"}, {15'd0, ir_wen}, {15'd0, wen});
    cmp({nm, ".inst"}, inst_out, inst);
    cmp({nm, ".ipc"}, inst_pc, ipc);
  endtask

  task automatic cyc(input logic st, input logic rd,
                     input logic [15:0] rpc, input logic ack,
                     input logic [15:0] rdat);
    @(negedge clk);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    mem_ack     = ack;
    mem_rdata   = rdat;
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h1111,
                1'b1, 16'h0000, 1'b0, 1'b0, 16'h4300, 16'h0000};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h2222,
                1'b1, 16'h0002, 1'b1, 1'b1, 16'h1111, 16'h0000};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h3333,
                1'b1, 16'h0004, 1'b1, 1'b1, 16'h2222, 16'h0002};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000,
                1'b1, 16'h0006, 1'b1, 1'b1, 16'h3333, 16'h0004};
    tbl[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000,
                1'b1, 16'h0006, 1'b0, 1'b0, 16'h4300, 16'h0000};
    tbl[5]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'hAAAA,
                1'b1, 16'h0006, 1'b0, 1'b0, 16'h4300, 16'h0000};
    tbl[6]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'hBBBB,
                1'b1, 16'h0008, 1'b1, 1'b0, 16'hAAAA, 16'h0006};
    tbl[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'hCCCC,
                1'b0, 16'h000A, 1'b1, 1'b0, 16'hAAAA, 16'h0006};
    tbl[8]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'hCCCC,
                1'b0, 16'h000A, 1'b1, 1'b0, 16'hAAAA, 16'h0006};
    tbl[9]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000,
                1'b0, 16'h000A, 1'b1, 1'b0, 16'hAAAA, 16'h0006};
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000,
                1'b0, 16'h000A, 1'b1, 1'b1, 16'hAAAA, 16'h0006};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000,
                1'b1, 16'h000A, 1'b1, 1'b1, 16'hBBBB, 16'h0008};
    tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000,
                1'b1, 16'h000A, 1'b0, 1'b0, 16'h4300, 16'h0000};
    tbl[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234,
                1'b1, 16'h000A, 1'b0, 1'b0, 16'h4300, 16'h0000};
    tbl[14] = '{1'b0, 1'b1, 16'h0040, 1'b1, 16'h5555,
                1'b1, 16'h000C, 1'b1, 1'b0, 16'h1234, 16'h000A};
    tbl[15] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000,
                1'b1, 16'h0040, 1'b0, 1'b0, 16'h4300, 16'h0000};
    tbl[16] = '{1'b0, 1'b1, 16'hFFFF, 1'b1, 16'h9999,
                1'b1, 16'h0040, 1'b0, 1'b0, 16'h4300, 16'h0000};
    tbl[17] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h7777,
                1'b1, 16'hFFFE, 1'b0, 1'b0, 16'h4300, 16'h0000};
    tbl[18] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h8888,
                1'b1, 16'h0000, 1'b1, 1'b1, 16'h7777, 16'hFFFE};
    tbl[19] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000,
                1'b1, 16'h0002, 1'b1, 1'b1, 16'h8888, 16'h0000};
    tbl[20] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000,
                1'b1, 16'h0002, 1'b0, 1'b0, 16'h4300, 16'h0000};

    resetn      = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    mem_ack     = 1'b0;
    mem_rdata   = 16'h0000;
    @(negedge clk);
    #1;
    chk("rst", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h4300, 16'h0000);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 21; i++) begin
      cyc(tbl[i].st, tbl[i].rd, tbl[i].rpc, tbl[i].ack, tbl[i].rdat);
      chk($sformatf("v%0d", i), tbl[i].req, tbl[i].addr,
          tbl[i].vld, tbl[i].wen, tbl[i].inst, tbl[i].ipc);
    end

    // 3-cycle ack, redirect in wait cycle 1
    cyc(1'b0, 1'b1, 16'h0101, 1'b0, 16'h0000);
    chk("dr.w1", 1'b1, 16'h0002, 1'b0, 1'b0, 16'h4300, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    chk("dr.w2", 1'b1, 16'h0002, 1'b0, 1'b0, 16'h4300, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 16'hDEAD);
    chk("dr.ack", 1'b1, 16'h0002, 1'b0, 1'b0, 16'h4300, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4444);
    chk("dr.new", 1'b1, 16'h0100, 1'b0, 1'b0, 16'h4300, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    chk("dr.out", 1'b1, 16'h0102, 1'b1, 1'b1, 16'h4444, 16'h0100);

    // second redirect while draining
    cyc(1'b0, 1'b1, 16'h0300, 1'b0, 16'h0000);
    chk("rr.1", 1'b1, 16'h0102, 1'b0, 1'b0, 16'h4300, 16'h0000);
    cyc(1'b0, 1'b1, 16'h0500, 1'b0, 16'h0000);
    chk("rr.2", 1'b1, 16'h0102, 1'b0, 1'b0, 16'h4300, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 16'hBEEF);
    chk("rr.3", 1'b1, 16'h0102, 1'b0, 1'b0, 16'h4300, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 16'h5151);
    chk("rr.4", 1'b1, 16'h0500, 1'b0, 1'b0, 16'h4300, 16'h0000);

    // asynchronous reset with a valid entry and a pending request
    cyc(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    chk("ar.pre", 1'b1, 16'h0502, 1'b1, 1'b1, 16'h5151, 16'h0500);
    #1;
    resetn = 1'b0;
    #1;
    chk("ar.in", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h4300, 16'h0000);
    cmp("ar.addr", mem_addr, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    resetn = 1'b1;
    #1;
    chk("ar.rel", 1'b1, 16'h0000, 1'b0, 1'b0, 16'h4300, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 16'h6060);
    chk("ar.f0", 1'b1, 16'h0000, 1'b0, 1'b0, 16'h4300, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    chk("ar.f1", 1'b1, 16'h0002, 1'b1, 1'b1, 16'h6060, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
